counter_prog: RTL and testbench

- Parametrised up/down counter, successor to the fixed 4-bit free-running counter in the user project area.
- Adds:
  - programmable width
  - runtime modulo limit
  - wrap or saturate mode
  - synchronous load
  - clock prescaler
  - one-cycle terminal-count pulse
- Drives Caravel user IO. Output enables are tied active (0) so the count appears on pads.

---
 rtl/counter_pkg.sv | 7 +
 rtl/counter_presc.sv | 21 ++
 rtl/counter_prog.sv | 52 +++++
 tb/tb_counter_prog.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode and direction encodings for the programmable counter
package counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/counter_presc.sv
// counter_presc: enable-gated prescaler, tick every presc+1 enabled cycles
// ports: clk, reset (async, active-high), en (gates counting), presc (divide value),
//        clr (restart period), tick (combinational step strobe)
module counter_presc #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);
  logic [PRESC_W-1:0] pc;
  // >= rather than == so that lowering presc below pc ends the period at once
  assign tick = en && (pc >= presc);
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (clr) pc <= '0;
    else if (en) pc <= tick ? '0 : pc + 1'b1;
endmodule

// File: rtl/counter_prog.sv
// counter_prog: prescaled up/down counter with runtime limit, wrap/saturate, load and terminal-count pulse
// ports: clk, reset (async, active-high), en, up_dn, load, load_val, limit, sat_mode, presc,
//        count (registered), tc (registered one-cycle pulse), io_oeb (pads always driven)
module counter_prog
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic               sat_mode,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic [WIDTH-1:0]   io_oeb
);
  logic tick, at_top, at_bot, nxt_tc;
  logic [WIDTH-1:0] nxt;
  assign io_oeb = '0;
  counter_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .presc(presc),
    .clr  (load),
    .tick (tick)
  );
  // >= so a count stranded above a lowered limit still wraps/saturates when counting up
  assign at_top = count >= limit;
  assign at_bot = count == '0;
  always_comb begin
    nxt = load ? ((load_val > limit) ? limit : load_val)
        : !tick ? count
        : (up_dn == DIR_UP) ? (at_top ? ((sat_mode == MODE_SAT) ? limit : '0) : count + 1'b1)
        : (at_bot ? ((sat_mode == MODE_SAT) ? '0 : limit) : count - 1'b1);
    nxt_tc = !load && tick && ((up_dn == DIR_UP) ? at_top : at_bot);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      count <= nxt;
      tc    <= nxt_tc;
    end
endmodule

// File: tb/tb_counter_prog.sv
// tb_counter_prog: table-driven, scoreboard-checked bench for counter_prog
module tb_counter_prog;
  localparam int W = 8, P = 4;
  logic clk = 0, reset = 0, en = 0, up_dn = 0, load = 0, sat_mode = 0;
  logic [W-1:0] load_val = '0, limit = '0;
  logic [P-1:0] presc = '0;
  logic [W-1:0] count, io_oeb;
  logic tc;
  int checks = 0, errors = 0;

  typedef struct {
    logic en, up, ld, sat;
    logic [W-1:0] lv, lim;
    logic [P-1:0] ps;
    logic [W-1:0] ec;
    logic et;
  } vec_t;
  typedef struct {
    logic [W-1:0] c;
    logic t;
    int id;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];

  counter_prog #(.WIDTH(W), .PRESC_W(P)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .limit(limit), .sat_mode(sat_mode), .presc(presc), .count(count), .tc(tc), .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", nm, id, act, exp);
    end
  endtask

  task automatic expect_push(input logic [W-1:0] c, input logic t, input int id);
    exp_t e;
    e.c = c; e.t = t; e.id = id;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty at time %0t", $time);
      return;
    end
    e = sb.pop_front();
    chk("count", e.id, 32'(count), 32'(e.c));
    chk("tc", e.id, 32'(tc), 32'(e.t));
    chk("io_oeb", e.id, 32'(io_oeb), 32'd0);
  endtask

  task automatic add(input logic e, u, l, s, input int lv, lim, ps, ec, input logic et);
    vec_t v;
    v.en = e; v.up = u; v.ld = l; v.sat = s;
    v.lv = W'(lv); v.lim = W'(lim); v.ps = P'(ps); v.ec = W'(ec); v.et = et;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    en = v.en; up_dn = v.up; load = v.ld; sat_mode = v.sat;
    load_val = v.lv; limit = v.lim; presc = v.ps;
    expect_push(v.ec, v.et, id);
    @(posedge clk);
    #1 check_out();
  endtask

  initial begin
    //  en up ld sat lv  lim  ps  count tc
    add(1, 1, 0, 0, 0, 5, 0, 1, 0);
    add(1, 1, 0, 0, 0, 5, 0, 2, 0);
    add(1, 1, 0, 0, 0, 5, 0, 3, 0);
    add(1, 1, 0, 0, 0, 5, 0, 4, 0);
    add(1, 1, 0, 0, 0, 5, 0, 5, 0);
    add(1, 1, 0, 0, 0, 5, 0, 0, 1);
    add(1, 1, 0, 0, 0, 5, 0, 1, 0);
    add(1, 1, 1, 1, 0, 3, 0, 0, 0);
    add(1, 1, 0, 1, 0, 3, 0, 1, 0);
    add(1, 1, 0, 1, 0, 3, 0, 2, 0);
    add(1, 1, 0, 1, 0, 3, 0, 3, 0);
    add(1, 1, 0, 1, 0, 3, 0, 3, 1);
    add(1, 1, 0, 1, 0, 3, 0, 3, 1);
    add(1, 0, 1, 0, 0, 9, 0, 0, 0);
    add(1, 0, 0, 0, 0, 9, 0, 9, 1);
    add(1, 0, 0, 0, 0, 9, 0, 8, 0);
    add(1, 0, 0, 0, 0, 9, 0, 7, 0);
    add(1, 0, 1, 1, 0, 9, 0, 0, 0);
    add(1, 0, 0, 1, 0, 9, 0, 0, 1);
    add(1, 0, 0, 1, 0, 9, 0, 0, 1);
    add(1, 1, 1, 1, 200, 100, 0, 100, 0);
    add(1, 1, 0, 1, 0, 100, 0, 100, 1);
    add(0, 1, 1, 1, 42, 100, 0, 42, 0);
    add(0, 1, 0, 1, 0, 100, 0, 42, 0);
    add(1, 0, 0, 0, 0, 10, 0, 41, 0);
    add(1, 1, 0, 0, 0, 10, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 255, 2, 0, 0);
    add(1, 1, 0, 0, 0, 255, 2, 0, 0);
    add(1, 1, 0, 0, 0, 255, 2, 0, 0);
    add(0, 1, 0, 0, 0, 255, 2, 0, 0);
    add(0, 1, 0, 0, 0, 255, 2, 0, 0);
    add(0, 1, 0, 0, 0, 255, 2, 0, 0);
    add(0, 1, 0, 0, 0, 255, 2, 0, 0);
    add(1, 1, 0, 0, 0, 255, 2, 1, 0);
    add(1, 1, 0, 0, 0, 255, 2, 1, 0);
    add(1, 1, 0, 0, 0, 255, 2, 1, 0);
    add(1, 1, 0, 0, 0, 255, 2, 2, 0);
    add(1, 1, 0, 0, 0, 255, 3, 2, 0);
    add(1, 1, 0, 0, 0, 255, 3, 2, 0);
    add(1, 1, 0, 0, 0, 255, 1, 3, 0);
    add(1, 1, 0, 0, 0, 255, 1, 3, 0);
    add(1, 1, 0, 0, 0, 255, 1, 4, 0);
    add(1, 1, 1, 1, 7, 7, 0, 7, 0);
    add(1, 1, 0, 1, 0, 7, 0, 7, 1);

    #2 reset = 1;
    #1 expect_push('0, 1'b0, -1);
    check_out();
    repeat (2) @(posedge clk);
    #1 expect_push('0, 1'b0, -2);
    check_out();
    @(negedge clk) reset = 0;

    foreach (vecs[i]) apply(vecs[i], i);

    // async reset between edges while count is 7 and tc is high
    @(negedge clk);
    #2 reset = 1; load = 1; load_val = 8'd50;
    #1 expect_push('0, 1'b0, 100);
    check_out();
    @(posedge clk);
    #1 expect_push('0, 1'b0, 101);
    check_out();
    @(negedge clk) reset = 0; load = 0; en = 0;
    expect_push('0, 1'b0, 102);
    @(posedge clk);
    #1 check_out();
    @(negedge clk) en = 1; up_dn = 1; sat_mode = 0; limit = 8'd7; presc = '0;
    expect_push(8'd1, 1'b0, 103);
    @(posedge clk);
    #1 check_out();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard left %0d entries", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
